// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: issues sequential word reads, buffers responses in an
// in-order prefetch FIFO with a registered head, and flushes on redirect.
module ifu_prefetch #(
    parameter int                     p_ADDR_BITS = 32,
    parameter int                     p_DATA_BITS = 32,
    parameter logic [p_ADDR_BITS-1:0] p_RESET_PC  = 32'h0000_0000,
    parameter int                     p_DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [p_ADDR_BITS-1:0] imem_addr,
    output logic                   imem_cmd,
    output logic [1:0]             imem_size,
    output logic                   imem_valid,
    input  logic                   imem_ready,
    input  logic                   imem_r_valid,
    output logic                   imem_r_ready,
    input  logic [p_DATA_BITS-1:0] imem_r_data,
    input  logic                   imem_r_resp,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [p_DATA_BITS-1:0] inst_data,
    output logic [p_ADDR_BITS-1:0] inst_pc,
    output logic                   inst_err,
    input  logic                   redirect_valid,
    input  logic [p_ADDR_BITS-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STOP  = 2'b10,
        S_DRAIN = 2'b11
    } state_t;

    localparam int c_PTR_BITS = $clog2(p_DEPTH);
    localparam int c_CNT_BITS = c_PTR_BITS + 1;
    localparam logic [c_CNT_BITS-1:0]  c_CNT_ZERO = {c_CNT_BITS{1'b0}};
    localparam logic [c_CNT_BITS-1:0]  c_CNT_ONE  = {{(c_CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_BITS-1:0]  c_CNT_FULL = c_CNT_BITS'(p_DEPTH);
    localparam logic [c_PTR_BITS-1:0]  c_PTR_ZERO = {c_PTR_BITS{1'b0}};
    localparam logic [c_PTR_BITS-1:0]  c_PTR_ONE  = {{(c_PTR_BITS-1){1'b0}}, 1'b1};
    localparam logic [p_ADDR_BITS-1:0] c_PC_STEP  = {{(p_ADDR_BITS-3){1'b0}}, 3'b100};

    state_t                 state_r, state_s;
    logic [p_ADDR_BITS-1:0] pc_r, rsp_pc_r, redirect_base_s;
    logic [c_CNT_BITS-1:0]  cnt_r, out_r, drop_r, cnt_s, out_s, drop_s;
    logic [c_CNT_BITS-1:0]  issue_inc_s, rsp_dec_s, push_inc_s, pop_dec_s, left_s;
    logic [c_CNT_BITS:0]    used_s;
    logic [c_PTR_BITS-1:0]  rd_ptr_r, wr_ptr_r, rd_next_s;
    logic [p_DATA_BITS-1:0] mem_data_r [p_DEPTH];
    logic [p_ADDR_BITS-1:0] mem_pc_r   [p_DEPTH];
    logic [p_DEPTH-1:0]     mem_err_r;
    logic                   head_valid_r, head_valid_s, head_err_r, head_err_s;
    logic [p_DATA_BITS-1:0] head_data_r, head_data_s;
    logic [p_ADDR_BITS-1:0] head_pc_r, head_pc_s;
    logic                   room_s, fetch_s, issue_s, push_s, pop_s, drop_active_s;
    logic                   redirect_lsb_unused_s;

    assign redirect_base_s       = {redirect_pc[p_ADDR_BITS-1:2], 2'b00};
    assign redirect_lsb_unused_s = ^redirect_pc[1:0];

    // Space is reserved at issue time, so FIFO entries plus in-flight reads never exceed the depth.
    assign used_s        = {1'b0, cnt_r} + {1'b0, out_r};
    assign room_s        = (used_s < {1'b0, c_CNT_FULL});
    assign fetch_s       = (state_r == S_RUN) && room_s && !redirect_valid;
    assign issue_s       = fetch_s && imem_ready;
    assign drop_active_s = (drop_r != c_CNT_ZERO);
    assign push_s        = imem_r_valid && !drop_active_s && !redirect_valid;
    assign pop_s         = head_valid_r && inst_ready && !redirect_valid;

    assign issue_inc_s = {{(c_CNT_BITS-1){1'b0}}, issue_s};
    assign rsp_dec_s   = {{(c_CNT_BITS-1){1'b0}}, imem_r_valid};
    assign push_inc_s  = {{(c_CNT_BITS-1){1'b0}}, push_s};
    assign pop_dec_s   = {{(c_CNT_BITS-1){1'b0}}, pop_s};
    assign left_s      = cnt_r - pop_dec_s;
    assign rd_next_s   = rd_ptr_r + (pop_s ? c_PTR_ONE : c_PTR_ZERO);

    assign imem_addr    = pc_r;
    assign imem_cmd     = 1'b0;
    assign imem_size    = 2'b10;
    assign imem_valid   = fetch_s;
    assign imem_r_ready = 1'b1;
    assign inst_valid   = head_valid_r && !redirect_valid;
    assign inst_data    = head_data_r;
    assign inst_pc      = head_pc_r;
    assign inst_err     = head_err_r;

    // Occupancy, in-flight and drop counters; a redirect turns every read still in flight into a drop.
    always_comb begin
        cnt_s  = cnt_r;
        out_s  = out_r;
        drop_s = drop_r;
        if (redirect_valid) begin
            cnt_s  = c_CNT_ZERO;
            out_s  = out_r - rsp_dec_s;
            drop_s = out_r - rsp_dec_s;
        end else begin
            cnt_s = cnt_r + push_inc_s - pop_dec_s;
            out_s = out_r + issue_inc_s - rsp_dec_s;
            if (imem_r_valid && drop_active_s) begin
                drop_s = drop_r - c_CNT_ONE;
            end else begin
                drop_s = drop_r;
            end
        end
    end

    // Next registered head: next stored entry, else the response being pushed into an empty FIFO.
    always_comb begin
        head_valid_s = head_valid_r;
        head_data_s  = head_data_r;
        head_pc_s    = head_pc_r;
        head_err_s   = head_err_r;
        if (redirect_valid) begin
            head_valid_s = 1'b0;
        end else if (left_s != c_CNT_ZERO) begin
            head_valid_s = 1'b1;
            head_data_s  = mem_data_r[rd_next_s];
            head_pc_s    = mem_pc_r[rd_next_s];
            head_err_s   = mem_err_r[rd_next_s];
        end else if (push_s) begin
            head_valid_s = 1'b1;
            head_data_s  = imem_r_data;
            head_pc_s    = rsp_pc_r;
            head_err_s   = imem_r_resp;
        end else begin
            head_valid_s = 1'b0;
        end
    end

    // Fetch FSM next state; redirect overrides every state.
    always_comb begin
        state_s = state_r;
        if (redirect_valid) begin
            state_s = (drop_s != c_CNT_ZERO) ? S_DRAIN : S_RUN;
        end else begin
            case (state_r)
                S_IDLE:  state_s = S_RUN;
                S_RUN:   state_s = (push_s && imem_r_resp) ? S_STOP : S_RUN;
                S_STOP:  state_s = S_STOP;
                S_DRAIN: state_s = (drop_s == c_CNT_ZERO) ? S_RUN : S_DRAIN;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // Control state, pointers, fetch/response addresses and the registered head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            pc_r         <= p_RESET_PC;
            rsp_pc_r     <= p_RESET_PC;
            cnt_r        <= c_CNT_ZERO;
            out_r        <= c_CNT_ZERO;
            drop_r       <= c_CNT_ZERO;
            rd_ptr_r     <= c_PTR_ZERO;
            wr_ptr_r     <= c_PTR_ZERO;
            head_valid_r <= 1'b0;
            head_data_r  <= {p_DATA_BITS{1'b0}};
            head_pc_r    <= p_RESET_PC;
            head_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            out_r        <= out_s;
            drop_r       <= drop_s;
            head_valid_r <= head_valid_s;
            head_data_r  <= head_data_s;
            head_pc_r    <= head_pc_s;
            head_err_r   <= head_err_s;
            if (redirect_valid) begin
                pc_r     <= redirect_base_s;
                rsp_pc_r <= redirect_base_s;
                rd_ptr_r <= c_PTR_ZERO;
                wr_ptr_r <= c_PTR_ZERO;
            end else begin
                pc_r     <= issue_s ? (pc_r + c_PC_STEP) : pc_r;
                rsp_pc_r <= push_s ? (rsp_pc_r + c_PC_STEP) : rsp_pc_r;
                wr_ptr_r <= push_s ? (wr_ptr_r + c_PTR_ONE) : wr_ptr_r;
                rd_ptr_r <= rd_next_s;
            end
        end
    end

    // FIFO storage; entries are written only by kept responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < p_DEPTH; i++) begin
                mem_data_r[i] <= {p_DATA_BITS{1'b0}};
                mem_pc_r[i]   <= p_RESET_PC;
            end
            mem_err_r <= {p_DEPTH{1'b0}};
        end else if (push_s) begin
            mem_data_r[wr_ptr_r] <= imem_r_data;
            mem_pc_r[wr_ptr_r]   <= rsp_pc_r;
            mem_err_r[wr_ptr_r]  <= imem_r_resp;
        end else begin
            mem_err_r <= mem_err_r;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: a memory responder predicts delivered instructions,
// a separate monitor pops and compares them at each decode handshake.
module tb_ifu_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_cmd;
    logic [1:0]  imem_size;
    logic        imem_valid;
    logic        imem_ready;
    logic        imem_r_valid;
    logic        imem_r_ready;
    logic [31:0] imem_r_data;
    logic        imem_r_resp;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ifu_prefetch dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_cmd(imem_cmd), .imem_size(imem_size),
        .imem_valid(imem_valid), .imem_ready(imem_ready),
        .imem_r_valid(imem_r_valid), .imem_r_ready(imem_r_ready),
        .imem_r_data(imem_r_data), .imem_r_resp(imem_r_resp),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_err(inst_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } exp_t;
    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;

    exp_t        exp_q[$];
    req_t        pend_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 1;
    int          epoch = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0000_0008;
    logic [31:0] exp_addr = 32'h0000_0000;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Memory responder: tracks the expected fetch address and queues expected instructions.
    initial begin : responder
        req_t drv_req;
        logic drv_rsp;
        logic drv_err;
        drv_rsp = 1'b0;
        drv_err = 1'b0;
        drv_req = '{32'h0000_0000, 0, 0};
        imem_r_valid = 1'b0;
        imem_r_data  = 32'h0000_0000;
        imem_r_resp  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (redirect_valid) begin
                    check("redirect_no_issue", {31'b0, imem_valid}, 32'd0);
                    check("redirect_no_inst", {31'b0, inst_valid}, 32'd0);
                    epoch++;
                    exp_q.delete();
                    exp_addr = {redirect_pc[31:2], 2'b00};
                end
                if (imem_valid && imem_ready) begin
                    check("imem_addr", imem_addr, exp_addr);
                    pend_q.push_back('{exp_addr, epoch, cyc + lat});
                    exp_addr = exp_addr + 32'd4;
                    acc_cnt++;
                end
                if (drv_rsp && drv_req.epoch == epoch) begin
                    exp_q.push_back('{drv_req.addr, mem_word(drv_req.addr), drv_err});
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            drv_rsp = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                drv_req = pend_q.pop_front();
                drv_rsp = 1'b1;
            end
            drv_err      = drv_rsp && err_en && (drv_req.addr == err_addr);
            imem_r_valid = drv_rsp;
            imem_r_data  = drv_rsp ? mem_word(drv_req.addr) : 32'h0000_0000;
            imem_r_resp  = drv_err;
        end
    end

    // Monitor: every decode handshake must match the oldest expected instruction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && inst_valid && inst_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL inst_unexpected: got pc %h data %h, expected no instruction",
                             inst_pc, inst_data);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_pc !== e.pc || inst_data !== e.data || inst_err !== e.err) begin
                        n_bad++;
                        $display("FAIL inst_head: got pc %h data %h err %b, expected pc %h data %h err %b",
                                 inst_pc, inst_data, inst_err, e.pc, e.data, e.err);
                    end
                end
            end
        end
    end

    // Directed sequence.
    initial begin : stim
        int k;
        int base;
        rst            = 1'b0;
        imem_ready     = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        k              = 0;

        repeat (3) @(posedge clk);
        samp();
        check("rst_imem_valid", {31'b0, imem_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst_err", {31'b0, inst_err}, 32'd0);
        check("rst_inst_data", inst_data, 32'h0000_0000);
        check("rst_inst_pc", inst_pc, 32'h0000_0000);
        check("rst_imem_addr", imem_addr, 32'h0000_0000);
        check("rst_consts", {28'b0, imem_cmd, imem_size, imem_r_ready}, 32'h0000_0005);

        tick();
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (inst_valid && k == 0) k = i;
        end
        check("first_valid_latency", k, 32'd3);
        check("stall_accepts", acc_cnt, 32'd4);
        check("stall_no_issue", {31'b0, imem_valid}, 32'd0);
        check("stall_head_pc", inst_pc, 32'h0000_0000);

        tick();
        inst_ready = 1'b1;
        repeat (12) tick();

        // Two reads in flight when the redirect arrives.
        imem_ready = 1'b0;
        repeat (8) tick();
        lat = 3;
        tick(); imem_ready = 1'b1;
        tick();
        tick(); imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        tick(); redirect_valid = 1'b0; imem_ready = 1'b1;
        samp(); check("drain_hold_1", {31'b0, imem_valid}, 32'd0);
        tick(); samp(); check("drain_hold_2", {31'b0, imem_valid}, 32'd0);
        tick(); samp();
        check("drain_restart_valid", {31'b0, imem_valid}, 32'd1);
        check("drain_restart_addr", imem_addr, 32'h0000_0100);
        repeat (15) tick();

        // Access error at 0x8 stops fetch until a redirect.
        imem_ready = 1'b0;
        repeat (10) tick();
        lat    = 1;
        err_en = 1'b1;
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0000; imem_ready = 1'b1;
        base = acc_cnt;
        tick(); redirect_valid = 1'b0;
        repeat (12) tick();
        samp();
        check("err_accepts", acc_cnt - base, 32'd4);
        check("err_stop", {31'b0, imem_valid}, 32'd0);
        err_en = 1'b0;
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        tick(); redirect_valid = 1'b0;
        samp();
        check("err_restart_valid", {31'b0, imem_valid}, 32'd1);
        check("err_restart_addr", imem_addr, 32'h0000_0040);

        // Redirect coinciding with a response and a would-be pop.
        lat = 2;
        repeat (12) tick();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick(); redirect_valid = 1'b0;
        samp(); check("coinc_drain", {31'b0, imem_valid}, 32'd0);
        tick(); samp();
        check("coinc_restart_valid", {31'b0, imem_valid}, 32'd1);
        check("coinc_restart_addr", imem_addr, 32'h0000_0200);
        repeat (10) tick();

        // Address wrap past the top of the space.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick(); redirect_valid = 1'b0;
        repeat (12) tick();

        imem_ready = 1'b0;
        repeat (10) tick();
        samp();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("wrap_reached", {31'b0, (acc_cnt > 0) && (exp_addr < 32'h0000_0100)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
